// File: rtl/pulse_receiver.sv
// Decodes width-qualified pulses from an asynchronous line into a 3-deep pending-event
// counter, with rejection strobe, wrapping accept counter and sticky overflow flag.
module pulse_receiver #(
    parameter int unsigned MIN_HIGH = 6,
    parameter int unsigned MAX_HIGH = 10,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             line_in,
    input  logic             evt_ready,
    input  logic             ovf_clr,
    output logic             evt_valid,
    output logic [1:0]       pend_cnt,
    output logic [CNT_W-1:0] evt_total,
    output logic             err_pulse,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        STUCK
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       width_q, width_d;
    logic             sync1_q, sync2_q;
    logic             err_q, err_d;
    logic [1:0]       pend_q, pend_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             ovf_q, ovf_d;

    logic line_s;
    logic acc;
    logic take;
    logic drop;

    assign line_s = sync2_q;
    assign take   = (pend_q != 2'd0) && evt_ready;

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        err_d   = 1'b0;
        acc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (line_s) begin
                    state_d = HIGH;
                    width_d = 4'd1;
                end
            end
            HIGH: begin
                if (line_s) begin
                    if (width_q == 4'(MAX_HIGH)) begin
                        state_d = STUCK;
                        err_d   = 1'b1;
                    end else begin
                        width_d = width_q + 4'd1;
                    end
                end else begin
                    if (width_q >= 4'(MIN_HIGH)) acc = 1'b1;
                    else                         err_d = 1'b1;
                    state_d = IDLE;
                    width_d = 4'd0;
                end
            end
            STUCK: begin
                if (!line_s) begin
                    state_d = IDLE;
                    width_d = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                width_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        pend_d  = pend_q;
        drop    = 1'b0;
        total_d = total_q;
        if (acc) total_d = total_q + CNT_W'(1);
        if (acc && !take) begin
            if (pend_q == 2'd3) drop = 1'b1;
            else                pend_d = pend_q + 2'd1;
        end else if (!acc && take) begin
            pend_d = pend_q - 2'd1;
        end
        // A drop in the same cycle as a clear leaves the flag set.
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            width_q <= '0;
            err_q   <= 1'b0;
            pend_q  <= '0;
            total_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            width_q <= width_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            total_q <= total_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_valid = (pend_q != 2'd0);
    assign pend_cnt  = pend_q;
    assign evt_total = total_q;
    assign err_pulse = err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_receiver.sv
// Directed bench for pulse_receiver: hand-derived cycle timing of accept, reject,
// stuck-line, overflow and reset behaviour.
module tb_pulse_receiver;

    logic        clk;
    logic        rst;
    logic        line_in;
    logic        evt_ready;
    logic        ovf_clr;
    logic        evt_valid;
    logic [1:0]  pend_cnt;
    logic [15:0] evt_total;
    logic        err_pulse;
    logic        ovf;

    int errors;
    int checks;
    int valid_cnt;
    int err_cnt;
    int first_valid;
    int first_err;
    logic rdy_default;

    pulse_receiver #(
        .MIN_HIGH(6),
        .MAX_HIGH(10),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .line_in(line_in),
        .evt_ready(evt_ready),
        .ovf_clr(ovf_clr),
        .evt_valid(evt_valid),
        .pend_cnt(pend_cnt),
        .evt_total(evt_total),
        .err_pulse(err_pulse),
        .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Tick i drives values sampled at edge i+1; observations are indexed by that edge.
    task automatic run(input int n_high, input int n_total, input int rdy_tick, input int clr_tick);
        valid_cnt   = 0;
        err_cnt     = 0;
        first_valid = 0;
        first_err   = 0;
        for (int i = 0; i < n_total; i++) begin
            line_in   = (i < n_high);
            evt_ready = (i == rdy_tick) ? 1'b1 : rdy_default;
            ovf_clr   = (i == clr_tick);
            @(posedge clk);
            #1;
            if (evt_valid) begin
                if (valid_cnt == 0) first_valid = i + 1;
                valid_cnt++;
            end
            if (err_pulse) begin
                if (err_cnt == 0) first_err = i + 1;
                err_cnt++;
            end
        end
        line_in   = 1'b0;
        evt_ready = rdy_default;
        ovf_clr   = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rdy_default = 1'b1;
        line_in     = 1'b0;
        evt_ready   = 1'b1;
        ovf_clr     = 1'b0;
        rst         = 1'b0;

        do_reset(3);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_pend",  32'(pend_cnt), 0);
        chk("rst_total", 32'(evt_total), 0);
        chk("rst_err",   32'(err_pulse), 0);
        chk("rst_ovf",   32'(ovf), 0);

        // 8-cycle pulse, consumer ready
        run(8, 20, -1, -1);
        chk("acc8_valid_cnt",   32'(valid_cnt), 1);
        chk("acc8_valid_edge",  32'(first_valid), 11);
        chk("acc8_err_cnt",     32'(err_cnt), 0);
        chk("acc8_total",       32'(evt_total), 1);
        chk("acc8_pend",        32'(pend_cnt), 0);

        // 3-cycle pulse: too short
        run(3, 15, -1, -1);
        chk("short_err_cnt",   32'(err_cnt), 1);
        chk("short_err_edge",  32'(first_err), 6);
        chk("short_valid_cnt", 32'(valid_cnt), 0);
        chk("short_total",     32'(evt_total), 1);

        // 20-cycle high: stuck line
        run(20, 30, -1, -1);
        chk("stuck_err_cnt",   32'(err_cnt), 1);
        chk("stuck_err_edge",  32'(first_err), 13);
        chk("stuck_valid_cnt", 32'(valid_cnt), 0);
        chk("stuck_total",     32'(evt_total), 1);
        run(8, 20, -1, -1);
        chk("after_stuck_valid", 32'(valid_cnt), 1);
        chk("after_stuck_edge",  32'(first_valid), 11);
        chk("after_stuck_total", 32'(evt_total), 2);

        // Overflow with consumer stalled
        do_reset(2);
        rdy_default = 1'b0;
        evt_ready   = 1'b0;
        for (int p = 0; p < 5; p++) run(8, 10, -1, -1);
        run(0, 15, -1, -1);
        chk("ovf5_pend",  32'(pend_cnt), 3);
        chk("ovf5_ovf",   32'(ovf), 1);
        chk("ovf5_valid", 32'(evt_valid), 1);
        chk("ovf5_total", 32'(evt_total), 5);

        run(0, 1, -1, 0);
        chk("clr_ovf",  32'(ovf), 0);
        chk("clr_pend", 32'(pend_cnt), 3);

        // Accept and take on the same edge at full occupancy
        run(8, 15, 10, -1);
        chk("acctake_pend",  32'(pend_cnt), 3);
        chk("acctake_ovf",   32'(ovf), 0);
        chk("acctake_total", 32'(evt_total), 6);

        // Clear on the same edge as an overflow
        run(8, 15, -1, 10);
        chk("clrset_ovf",   32'(ovf), 1);
        chk("clrset_total", 32'(evt_total), 7);
        chk("clrset_pend",  32'(pend_cnt), 3);

        // Drain
        rdy_default = 1'b1;
        run(0, 1, -1, -1);
        chk("drain1_pend", 32'(pend_cnt), 2);
        run(0, 1, -1, -1);
        chk("drain2_pend",  32'(pend_cnt), 1);
        chk("drain2_valid", 32'(evt_valid), 1);
        run(0, 1, -1, -1);
        chk("drain3_pend",  32'(pend_cnt), 0);
        chk("drain3_valid", 32'(evt_valid), 0);
        run(0, 2, -1, -1);
        chk("idle_ready_pend", 32'(pend_cnt), 0);

        // Reset in the middle of a pulse, held until the line drops
        err_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            line_in = (i < 8);
            rst     = (i >= 3);
            @(posedge clk);
            #1;
            if (err_pulse) err_cnt++;
        end
        chk("midrst_pend",  32'(pend_cnt), 0);
        chk("midrst_valid", 32'(evt_valid), 0);
        chk("midrst_total", 32'(evt_total), 0);
        chk("midrst_ovf",   32'(ovf), 0);
        chk("midrst_err",   32'(err_cnt), 0);
        rst = 1'b0;
        run(0, 20, -1, -1);
        chk("postrst_err",   32'(err_cnt), 0);
        chk("postrst_valid", 32'(valid_cnt), 0);
        chk("postrst_total", 32'(evt_total), 0);

        // Reset released while the line is already high
        line_in = 1'b1;
        rst     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        run(8, 20, -1, -1);
        chk("relhigh_valid", 32'(valid_cnt), 1);
        chk("relhigh_edge",  32'(first_valid), 11);
        chk("relhigh_err",   32'(err_cnt), 0);
        chk("relhigh_total", 32'(evt_total), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_receiver.md
PULSE_RECEIVER -- requirements
Module: pulse_receiver

Interface
REQ-001 SHALL provide parameter MIN_HIGH, default 6: minimum accepted pulse width in synchronized clk cycles.
REQ-002 SHALL provide parameter MAX_HIGH, default 10: maximum accepted pulse width in synchronized cycles, with MIN_HIGH <= MAX_HIGH <= 14.
REQ-003 SHALL provide parameter CNT_W, default 16: width of evt_total.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port line_in, input, 1 bit: asynchronous stretched pulse line from the remote sender.
REQ-007 SHALL have port evt_ready, input, 1 bit: consumer accepts one event.
REQ-008 SHALL have port ovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-009 SHALL have port evt_valid, output, 1 bit: at least one accepted event is pending.
REQ-010 SHALL have port pend_cnt, output, 2 bits: number of pending events, 0..3.
REQ-011 SHALL have port evt_total, output, CNT_W bits: count of accepted pulses, wrapping.
REQ-012 SHALL have port err_pulse, output, 1 bit: one-cycle strobe on a rejected pulse.
REQ-013 SHALL have port ovf, output, 1 bit: sticky flag, set when an accepted event is dropped.

Function
REQ-014 SHALL pass line_in through a 2-flop synchronizer (both flops reset to 0); line_s is the second-stage output, and all decoding SHALL use line_s only.
REQ-015 SHALL implement an FSM with states IDLE, HIGH and STUCK, plus a 4-bit width counter.
REQ-016 IDLE: when line_s==1, SHALL go to HIGH with width=1; otherwise SHALL stay in IDLE.
REQ-017 HIGH with line_s==1: if width==MAX_HIGH, SHALL go to STUCK and pulse err_pulse; else SHALL increment width.
REQ-018 HIGH with line_s==0: if width>=MIN_HIGH, SHALL accept one event; else SHALL pulse err_pulse; in both cases SHALL go to IDLE.
REQ-019 STUCK: SHALL stay while line_s==1 with no further err_pulse, and SHALL go to IDLE when line_s==0.
REQ-020 err_pulse SHALL be registered and high for exactly the cycle after the deciding cycle.
REQ-021 On accept, evt_total SHALL increment by 1 modulo 2^CNT_W, whether or not the event is dropped.
REQ-022 pend_cnt update per cycle, where acc = accept and take = evt_valid && evt_ready:
- acc only: +1, saturating at 3.
- take only: -1.
- acc and take together: unchanged.
REQ-023 acc with pend_cnt==3 and no take: SHALL drop the event and set ovf.
REQ-024 evt_valid SHALL equal (pend_cnt != 0); evt_ready while evt_valid==0 SHALL be ignored.
REQ-025 ovf_clr SHALL clear ovf; if the same cycle also sets ovf, the set SHALL win.
REQ-026 Latency: for line_in high during cycles t..t+7, line_s SHALL be high t+2..t+9, the decision SHALL occur at t+10, and evt_valid SHALL rise at t+11.
REQ-027 A pulse separated by a single low line_s cycle SHALL be decoded as a new pulse; no minimum gap applies.

Reset
REQ-028 While rst is high, SHALL hold: FSM=IDLE, width=0, synchronizer=0, pend_cnt=0, evt_valid=0, evt_total=0, err_pulse=0, ovf=0.
REQ-029 rst mid-pulse SHALL discard the partial measurement, and no event or error SHALL result from it.
REQ-030 After rst falls with line_in already high, SHALL decode the remaining pulse as a new pulse from IDLE.

Verification
REQ-031 8-cycle high on line_in, evt_ready=1 -> evt_valid high exactly 1 cycle at t+11, evt_total=1, err_pulse never high.
REQ-032 3-cycle high -> err_pulse for 1 cycle, evt_total=0, evt_valid=0.
REQ-033 Line held high 20 cycles -> single err_pulse when width reaches 10, then STUCK until low, no event; a following 8-cycle pulse is accepted.
REQ-034 evt_ready=0, five 8-cycle pulses with 2-cycle gaps -> pend_cnt=3, ovf=1, evt_total=5; then evt_ready=1 drains 3 events in 3 cycles.
REQ-035 Accept coinciding with take at pend_cnt=3 -> pend_cnt stays 3 and ovf stays 0; ovf_clr coinciding with overflow -> ovf=1.
REQ-036 rst asserted at cycle 4 of an 8-cycle pulse -> all outputs 0, no err_pulse, no event afterwards.
